// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : shared FSM encoding, port IDs and parameter limits for
//                   the two-port unified memory arbiter.
// Revision        : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic P_CORE = 1'b0;
  localparam logic P_LOAD = 1'b1;

  localparam int MEM_LAT_MIN = 1;

endpackage
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// ============================================================================
// arb_pick2 : combinational two-way winner selection.
//             MEMARB_RR_EN defined -> round-robin, else fixed priority port 0.
// Revision  : 1.0 - initial release
// ============================================================================
module arb_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic winner,
  output logic any_req
);

  assign any_req = req0 | req1;

`ifdef MEMARB_RR_EN
  always_comb begin
    winner = P_CORE;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = P_LOAD;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = P_CORE;
    if (req1 && !req0) begin
      winner = P_LOAD;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one synchronous memory port between the core (port 0)
//               and the loader/DMA engine (port 1), one access in flight.
//               Optional macro MEMARB_RR_EN selects round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

  if (MEM_LAT < MEM_LAT_MIN) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  state_t        state;
  state_t        state_nx;
  logic          owner;
  logic          rr_ptr;
  logic          last_owner;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wd_q;
  logic [CW-1:0] cnt;
  logic          winner;
  logic          any_req;

  // rr_ptr names the port holding priority; the picker wants the last grantee.
  assign last_owner = ~rr_ptr;

  arb_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = we_q ? IDLE : WAIT;
      WAIT:    if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt0    = (state == ACCESS) && (owner == P_CORE);
    gnt1    = (state == ACCESS) && (owner == P_LOAD);
    mem_we  = (state == ACCESS) && we_q;
    mem_adr = adr_q;
    mem_wd  = wd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= P_CORE;
      rr_ptr  <= P_CORE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      cnt     <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state   <= state_nx;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= winner;
            we_q  <= winner ? we1    : we0;
            adr_q <= winner ? addr1  : addr0;
            wd_q  <= winner ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          rr_ptr <= ~owner;
          if (!we_q) cnt <= LAT_LOAD;
        end
        WAIT: begin
          // Counter at zero marks the cycle in which mem_rd carries the data.
          if (cnt == '0) begin
            if (owner == P_CORE) begin
              rdata0  <= mem_rd;
              rvalid0 <= 1'b1;
            end else begin
              rdata1  <= mem_rd;
              rvalid1 <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter (main instance MEM_LAT=3,
//                  two extra instances MEM_LAT=1 and 5 for the latency sweep).
// Revision       : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int          LAT = 3;
  localparam logic [31:0] PAT = 32'h5A5A_0000;
`ifdef MEMARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } gexp_t;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } rexp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_adr, mem_wd, mem_rd;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // Synchronous memory: data for the address cycle appears LAT cycles later.
  logic [31:0] mem     [256];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (mem_we) mem[mem_adr[9:2]] <= mem_wd;
    rd_pipe[0] <= mem[mem_adr[9:2]];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rd = rd_pipe[LAT-1];

  // Latency sweep instances, port 1 reads only; memory returns addr ^ PAT.
  logic        xreq1   [2];
  logic [31:0] xaddr1  [2];
  logic        xgnt0   [2];
  logic        xgnt1   [2];
  logic        xrv0    [2];
  logic        xrv1    [2];
  logic        xmem_we [2];
  logic [31:0] xrdata0 [2];
  logic [31:0] xrdata1 [2];
  logic [31:0] xmem_adr[2];
  logic [31:0] xmem_wd [2];
  logic [31:0] xmem_rd [2];

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int L = (g == 0) ? 1 : 5;
    logic [31:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= xmem_adr[g] ^ PAT;
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign xmem_rd[g] = pipe[L-1];

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .req0(1'b0), .req1(xreq1[g]), .we0(1'b0), .we1(1'b0),
      .addr0(32'h0), .addr1(xaddr1[g]), .wdata0(32'h0), .wdata1(32'h0),
      .gnt0(xgnt0[g]), .gnt1(xgnt1[g]), .rvalid0(xrv0[g]), .rvalid1(xrv1[g]),
      .rdata0(xrdata0[g]), .rdata1(xrdata1[g]),
      .mem_adr(xmem_adr[g]), .mem_wd(xmem_wd[g]), .mem_we(xmem_we[g]),
      .mem_rd(xmem_rd[g])
    );
  end

  gexp_t       gq[$];
  rexp_t       rq[$];
  logic [31:0] shadow [256];
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a grant or read data.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (gnt0 || gnt1) begin
      if (gq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_gnt: got gnt0=%b gnt1=%b, expected no grant (cycle %0d)", gnt0, gnt1, cyc);
      end else begin
        g = gq.pop_front();
        chk1("gnt_onehot", gnt0 & gnt1, 1'b0);
        chk1("gnt_port", gnt1, g.port);
        chk1("gnt_mem_we", mem_we, g.we);
        chk("gnt_mem_adr", mem_adr, g.addr);
        if (g.we) chk("gnt_mem_wd", mem_wd, g.data);
      end
    end else if (mem_we) begin
      chk1("stray_mem_we", mem_we, 1'b0);
    end
    if (rvalid0 || rvalid1) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid0=%b rvalid1=%b, expected none (cycle %0d)", rvalid0, rvalid1, cyc);
      end else begin
        r = rq.pop_front();
        chk1("rvalid_port", rvalid1, r.port);
        chk("rdata", r.port ? rdata1 : rdata0, r.data);
      end
    end
  end

  task automatic txn(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input bit expect_rsp, output int gcyc, output int waited);
    gq.push_back('{port: p, we: w, addr: a, data: d});
    if (w) shadow[a[9:2]] = d;
    else if (expect_rsp) rq.push_back('{port: p, data: shadow[a[9:2]]});
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(p ? gnt1 : gnt0) && waited < 50);
    if (!(p ? gnt1 : gnt0)) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got no grant on port %0d after %0d cycles, expected a grant", p, waited);
    end
    gcyc = cyc;
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_rvalid(input logic p, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? rvalid1 : rvalid0) && n < 50);
  endtask

  initial begin
    int    gc [8];
    int    w, n, ng0, ng1;
    logic  saw_we, port;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 2; i++) begin xreq1[i] = 1'b0; xaddr1[i] = '0; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk1("rst_gnt0", gnt0, 1'b0);    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_rvalid0", rvalid0, 1'b0); chk1("rst_rvalid1", rvalid1, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_adr", mem_adr, 32'h0); chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);   chk("rst_rdata1", rdata1, 32'h0);

    // Contention: both ports hold write requests for 8 grants.
    for (int i = 0; i < 8; i++) begin
      port = RR ? i[0] : 1'b0;
      gq.push_back('{port: port, we: 1'b1, addr: port ? 32'h104 : 32'h100,
                     data: port ? 32'h1111_0001 : 32'h0000_0100});
    end
    shadow[32'h100 >> 2] = 32'h0000_0100;
    if (RR) shadow[32'h104 >> 2] = 32'h1111_0001;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h100; wdata0 = 32'h0000_0100;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h104; wdata1 = 32'h1111_0001;
    ng0 = 0; ng1 = 0; n = 0;
    while (ng0 + ng1 < 8 && n < 60) begin
      @(negedge clk);
      n++;
      if (gnt0) ng0++;
      if (gnt1) ng1++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_gnt0", ng0, RR ? 32'd4 : 32'd8);
    chk("cont_gnt1", ng1, RR ? 32'd4 : 32'd0);
    chk("cont_span", n, 32'd15);
    @(negedge clk);

    // Write then read of 0x40 on port 0.
    txn(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, gc[0], w);
    chk("wr_gnt_lat", w, 32'd1);
    @(negedge clk);
    txn(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, gc[0], w);
    chk("rd_gnt_lat", w, 32'd1);
    wait_rvalid(1'b0, n);
    chk("rd_rvalid_lat", n, LAT + 1);
    chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);

    // Back-to-back: 4 writes then 4 reads on port 0.
    for (int i = 0; i < 4; i++)
      txn(1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i * 32'h11), 1'b0, gc[i], w);
    for (int i = 0; i < 4; i++)
      txn(1'b0, 1'b0, 32'(i * 4), 32'h0, 1'b1, gc[4 + i], w);
    for (int i = 1; i < 4; i++) chk("b2b_wr_gap", gc[i] - gc[i-1], 32'd2);
    chk("b2b_wr_rd_gap", gc[4] - gc[3], 32'd2);
    // A read occupies IDLE + ACCESS + LAT WAIT cycles.
    for (int i = 5; i < 8; i++) chk("b2b_rd_gap", gc[i] - gc[i-1], LAT + 2);
    wait_rvalid(1'b0, n);
    chk("b2b_last_rd_lat", n, LAT + 1);

    // Latency from req1 rising in IDLE to rvalid1, main instance.
    txn(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, gc[0], w);
    wait_rvalid(1'b1, n);
    chk("lat_main", w + n, LAT + 2);

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=5 instances.
    for (int i = 0; i < 2; i++) begin
      xaddr1[i] = 32'h80 + 32'(i * 4);
      xreq1[i]  = 1'b1;
      n = 0;
      saw_we = 1'b0;
      do begin
        @(negedge clk);
        n++;
        if (xgnt1[i]) xreq1[i] = 1'b0;
        if (xmem_we[i]) saw_we = 1'b1;
      end while (!xrv1[i] && n < 40);
      xreq1[i] = 1'b0;
      chk("sweep_lat", n, (i == 0) ? 32'd3 : 32'd7);
      chk("sweep_rdata1", xrdata1[i], (32'h80 + 32'(i * 4)) ^ PAT);
      chk1("sweep_no_we", saw_we, 1'b0);
    end

    // Reset during the WAIT phase of a read: response must be discarded.
    txn(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, gc[0], w);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("mrst_gnt0", gnt0, 1'b0);      chk1("mrst_gnt1", gnt1, 1'b0);
    chk1("mrst_rvalid0", rvalid0, 1'b0); chk1("mrst_rvalid1", rvalid1, 1'b0);
    chk1("mrst_mem_we", mem_we, 1'b0);
    chk("mrst_mem_adr", mem_adr, 32'h0); chk("mrst_mem_wd", mem_wd, 32'h0);
    chk("mrst_rdata0", rdata0, 32'h0);   chk("mrst_rdata1", rdata1, 32'h0);
    repeat (LAT + 3) @(negedge clk);
    txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, gc[0], w);
    wait_rvalid(1'b1, n);
    chk("post_rst_rd_lat", n, LAT + 1);

    // Single requester on port 1: no bubbles beyond nominal spacing.
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      txn(1'b1, 1'b1, 32'h200 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b0, gc[i], w);
    chk("single_gap1", gc[1] - gc[0], 32'd2);
    chk("single_gap2", gc[2] - gc[1], 32'd2);
    txn(1'b1, 1'b0, 32'h208, 32'h0, 1'b1, gc[0], w);
    wait_rvalid(1'b1, n);
    chk("single_rd_rdata1", rdata1, 32'hC0DE_0002);

    repeat (LAT + 4) @(negedge clk);
    chk("gq_drained", gq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
